// File: rtl/lieat_ifu_fetch_q.sv
// lieat_ifu_fetch_q: sequential fetch issuer with an in-order queue of outstanding and buffered fetches
module lieat_ifu_fetch_q #(
    parameter int XLEN = 32,
    parameter int ILEN = 32,
    parameter int DEPTH = 2,
    parameter logic [XLEN-1:0] PC_RESET = 32'h8000_0000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic [XLEN-1:0]        flush_pc_i,
    input  logic                   redir_i,
    input  logic [XLEN-1:0]        redir_pc_i,
    input  logic                   hold_i,
    output logic                   req_o_valid,
    input  logic                   req_o_ready,
    output logic [XLEN-1:0]        req_o_pc,
    input  logic                   rsp_i_valid,
    input  logic [ILEN-1:0]        rsp_i_ir,
    output logic                   out_o_valid,
    input  logic                   out_o_ready,
    output logic [XLEN-1:0]        out_o_pc,
    output logic [ILEN-1:0]        out_o_ir,
    output logic [$clog2(DEPTH):0] occ_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [XLEN-1:0]  pc_q [DEPTH];
    logic [ILEN-1:0]  ir_q [DEPTH];
    logic [DEPTH-1:0] filled_q, killed_q;
    logic [AW-1:0]    alloc_ptr, fill_ptr, head_ptr;
    logic [AW:0]      occ;
    logic [XLEN-1:0]  fpc;
    logic             rst_d, kill, req_fire, head_ok, drop, pop;

    always_comb begin
        kill        = flush_i | redir_i;
        req_o_pc    = flush_i ? flush_pc_i : redir_i ? redir_pc_i : fpc;
        req_o_valid = ~reset & ~rst_d & (occ < FULL) & (~hold_i | flush_i);
        req_fire    = req_o_valid & req_o_ready;
        head_ok     = ~reset & ~rst_d & (occ != '0) & filled_q[head_ptr];
        out_o_valid = head_ok & ~killed_q[head_ptr] & ~kill;
        drop        = head_ok & killed_q[head_ptr];
        pop         = drop | (out_o_valid & out_o_ready);
        out_o_pc    = pc_q[head_ptr];
        out_o_ir    = ir_q[head_ptr];
        occ_o       = occ;
    end

    // Kill marks every older entry; an entry allocated this cycle is re-cleared below.
    always_ff @(posedge clock) begin
        if (reset) begin
            rst_d     <= 1'b1;
            fpc       <= PC_RESET;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            occ       <= '0;
            filled_q  <= '0;
            killed_q  <= '0;
        end else begin
            rst_d <= 1'b0;
            fpc   <= req_fire ? req_o_pc + XLEN'(4) : req_o_pc;
            occ   <= occ + (AW+1)'(req_fire) - (AW+1)'(pop);
            if (kill)
                killed_q <= '1;
            if (rsp_i_valid) begin
                filled_q[fill_ptr] <= 1'b1;
                ir_q[fill_ptr]     <= rsp_i_ir;
                fill_ptr           <= fill_ptr + AW'(1);
            end
            if (req_fire) begin
                pc_q[alloc_ptr]     <= req_o_pc;
                filled_q[alloc_ptr] <= 1'b0;
                killed_q[alloc_ptr] <= 1'b0;
                alloc_ptr           <= alloc_ptr + AW'(1);
            end
            if (pop)
                head_ptr <= head_ptr + AW'(1);
        end
    end
endmodule

// File: tb/tb_lieat_ifu_fetch_q.sv
// tb_lieat_ifu_fetch_q: scoreboard bench for a DEPTH=2 instance (a_*) and a DEPTH=4 instance (b_*)
module tb_lieat_ifu_fetch_q;
    localparam logic [31:0] PC_RESET = 32'h8000_0000;
    typedef struct { logic [31:0] pc; int due; } mreq_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        a_flush = 1'b0, a_redir = 1'b0, a_hold = 1'b0;
    logic [31:0] a_flush_pc = '0, a_redir_pc = '0;
    logic        a_req_ready = 1'b0, a_out_ready = 1'b0, a_rsp_valid = 1'b0;
    logic [31:0] a_rsp_ir = '0, a_req_pc, a_out_pc, a_out_ir;
    logic        a_req_valid, a_out_valid;
    logic [1:0]  a_occ;
    logic        b_zero = 1'b0;
    logic [31:0] b_zero_pc = '0;
    logic        b_req_ready = 1'b0, b_out_ready = 1'b0, b_rsp_valid = 1'b0;
    logic [31:0] b_rsp_ir = '0, b_req_pc, b_out_pc, b_out_ir;
    logic        b_req_valid, b_out_valid;
    logic [2:0]  b_occ;

    int          n_checks = 0, n_fail = 0, cyc = 0;
    int          lat_a = 1, lat_b = 3, a_ndel = 0, b_ndel = 0;
    bit          b_rand = 1'b0, a_pend = 1'b0, b_pend = 1'b0;
    logic [31:0] a_next = PC_RESET, b_next = PC_RESET, a_pend_pc = '0, b_pend_pc = '0;
    logic [31:0] exp_a[$], exp_b[$];
    mreq_t       mem_a[$], mem_b[$];

    always #5 clk = ~clk;

    lieat_ifu_fetch_q #(.DEPTH(2)) u_a (
        .clock(clk), .reset(rst),
        .flush_i(a_flush), .flush_pc_i(a_flush_pc), .redir_i(a_redir), .redir_pc_i(a_redir_pc),
        .hold_i(a_hold),
        .req_o_valid(a_req_valid), .req_o_ready(a_req_ready), .req_o_pc(a_req_pc),
        .rsp_i_valid(a_rsp_valid), .rsp_i_ir(a_rsp_ir),
        .out_o_valid(a_out_valid), .out_o_ready(a_out_ready), .out_o_pc(a_out_pc), .out_o_ir(a_out_ir),
        .occ_o(a_occ)
    );

    lieat_ifu_fetch_q #(.DEPTH(4)) u_b (
        .clock(clk), .reset(rst),
        .flush_i(b_zero), .flush_pc_i(b_zero_pc), .redir_i(b_zero), .redir_pc_i(b_zero_pc),
        .hold_i(b_zero),
        .req_o_valid(b_req_valid), .req_o_ready(b_req_ready), .req_o_pc(b_req_pc),
        .rsp_i_valid(b_rsp_valid), .rsp_i_ir(b_rsp_ir),
        .out_o_valid(b_out_valid), .out_o_ready(b_out_ready), .out_o_pc(b_out_pc), .out_o_ir(b_out_ir),
        .occ_o(b_occ)
    );

    function automatic logic [31:0] ir_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]};
    endfunction

    // Memory models: in-order responses a fixed number of cycles after each handshake.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        a_rsp_valid = 1'b0;
        b_rsp_valid = 1'b0;
        if (mem_a.size() > 0 && mem_a[0].due == cyc) begin
            a_rsp_valid = 1'b1;
            a_rsp_ir = ir_of(mem_a[0].pc);
            void'(mem_a.pop_front());
        end
        if (mem_b.size() > 0 && mem_b[0].due == cyc) begin
            b_rsp_valid = 1'b1;
            b_rsp_ir = ir_of(mem_b[0].pc);
            void'(mem_b.pop_front());
        end
        if (b_rand) begin
            b_out_ready = 1'(($urandom_range(0, 1)));
            b_req_ready = 1'(($urandom_range(0, 1)));
        end
    end

    // Reference model and scoreboard for both instances, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (a_pend && !rst && !a_flush && !a_redir && !a_hold) begin
            n_checks++;
            if (a_req_valid !== 1'b1 || a_req_pc !== a_pend_pc) begin
                n_fail++;
                $display("FAIL a_req_stable: valid=%b pc=%h, required 1 %h", a_req_valid, a_req_pc, a_pend_pc);
            end
        end
        if (b_pend && !rst) begin
            n_checks++;
            if (b_req_valid !== 1'b1 || b_req_pc !== b_pend_pc) begin
                n_fail++;
                $display("FAIL b_req_stable: valid=%b pc=%h, required 1 %h", b_req_valid, b_req_pc, b_pend_pc);
            end
        end
        if (a_flush || a_redir) begin
            n_checks++;
            if (a_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL a_kill_out: out_valid=%b, required 0", a_out_valid);
            end
            exp_a.delete();
            a_next = a_flush ? a_flush_pc : a_redir_pc;
        end
        if (a_out_valid && a_out_ready) begin
            n_checks++;
            a_ndel++;
            if (exp_a.size() == 0) begin
                n_fail++;
                $display("FAIL a_out_extra: pc=%h delivered, required nothing", a_out_pc);
            end else begin
                logic [31:0] e;
                e = exp_a.pop_front();
                if (a_out_pc !== e || a_out_ir !== ir_of(e)) begin
                    n_fail++;
                    $display("FAIL a_out: pc=%h ir=%h, required %h %h", a_out_pc, a_out_ir, e, ir_of(e));
                end
            end
        end
        if (b_out_valid && b_out_ready) begin
            n_checks++;
            b_ndel++;
            if (exp_b.size() == 0) begin
                n_fail++;
                $display("FAIL b_out_extra: pc=%h delivered, required nothing", b_out_pc);
            end else begin
                logic [31:0] e;
                e = exp_b.pop_front();
                if (b_out_pc !== e || b_out_ir !== ir_of(e)) begin
                    n_fail++;
                    $display("FAIL b_out: pc=%h ir=%h, required %h %h", b_out_pc, b_out_ir, e, ir_of(e));
                end
            end
        end
        if (a_req_valid && a_req_ready) begin
            n_checks++;
            if (a_req_pc !== a_next) begin
                n_fail++;
                $display("FAIL a_req_pc: pc=%h, required %h", a_req_pc, a_next);
            end
            exp_a.push_back(a_next);
            mem_a.push_back('{a_req_pc, cyc + lat_a});
            a_next += 32'd4;
        end
        if (b_req_valid && b_req_ready) begin
            n_checks++;
            if (b_req_pc !== b_next) begin
                n_fail++;
                $display("FAIL b_req_pc: pc=%h, required %h", b_req_pc, b_next);
            end
            exp_b.push_back(b_next);
            mem_b.push_back('{b_req_pc, cyc + lat_b});
            b_next += 32'd4;
        end
        a_pend = a_req_valid && !a_req_ready;
        a_pend_pc = a_req_pc;
        b_pend = b_req_valid && !b_req_ready;
        b_pend_pc = b_req_pc;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (a_req_valid !== 1'b0 || a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_a: req_valid=%b out_valid=%b occ=%0d, required 0 0 0", a_req_valid, a_out_valid, a_occ);
        end
        n_checks++;
        if (b_req_valid !== 1'b0 || b_out_valid !== 1'b0 || b_occ !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_b: req_valid=%b out_valid=%b occ=%0d, required 0 0 0", b_req_valid, b_out_valid, b_occ);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_req_valid !== 1'b0 || a_occ !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_gap: req_valid=%b occ=%0d, required 0 0", a_req_valid, a_occ);
        end
        @(negedge clk);
        n_checks++;
        if (a_req_valid !== 1'b1 || a_req_pc !== PC_RESET) begin
            n_fail++;
            $display("FAIL first_req: valid=%b pc=%h, required 1 %h", a_req_valid, a_req_pc, PC_RESET);
        end
    endtask

    task automatic test_drain_a();
        int t = 0;
        @(posedge clk);
        #1 a_req_ready = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        while ((a_occ !== 2'd0 || mem_a.size() != 0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 50 || exp_a.size() != 0) begin
            n_fail++;
            $display("FAIL drain_a: occ=%0d undelivered=%0d, required 0 0", a_occ, exp_a.size());
        end
    endtask

    task automatic test_stream();
        int n0;
        @(posedge clk);
        #1 a_req_ready = 1'b1;
        a_out_ready = 1'b1;
        n0 = a_ndel;
        repeat (30) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (a_ndel - n0 < 15) begin
            n_fail++;
            $display("FAIL stream_rate: delivered=%0d in 30 cycles, required >=15", a_ndel - n0);
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk);
        #1 a_out_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (a_occ !== 2'd2 || a_req_valid !== 1'b0 || a_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full: occ=%0d req_valid=%b out_valid=%b, required 2 0 1", a_occ, a_req_valid, a_out_valid);
        end
        @(posedge clk);
        #1 a_out_ready = 1'b1;
        repeat (10) @(posedge clk);
        test_drain_a();
    endtask

    task automatic test_flush();
        int t = 0, got = 0;
        logic [31:0] pcs [2];
        lat_a = 3;
        @(posedge clk);
        #1 a_req_ready = 1'b1;
        @(negedge clk);
        while (a_occ !== 2'd2 && t < 10) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (a_occ !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_setup: occ=%0d, required 2", a_occ);
        end
        @(posedge clk);
        #1 a_flush = 1'b1;
        a_flush_pc = 32'h100;
        @(negedge clk);
        n_checks++;
        if (a_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_full: req_valid=%b, required 0", a_req_valid);
        end
        @(posedge clk);
        #1 a_flush = 1'b0;
        t = 0;
        while (got < 2 && t < 40) begin
            @(negedge clk);
            t++;
            if (a_out_valid && a_out_ready) begin
                pcs[got] = a_out_pc;
                got++;
            end
        end
        n_checks++;
        if (got != 2 || pcs[0] !== 32'h100 || pcs[1] !== 32'h104) begin
            n_fail++;
            $display("FAIL flush_target: got=%0d pcs=%h %h, required 2 00000100 00000104", got, pcs[0], pcs[1]);
        end
        test_drain_a();
        lat_a = 1;
    endtask

    task automatic test_hold_redir();
        @(posedge clk);
        #1 a_hold = 1'b1;
        a_req_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (a_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_block: req_valid=%b, required 0", a_req_valid);
            end
        end
        @(posedge clk);
        #1 a_redir = 1'b1;
        a_redir_pc = 32'h200;
        @(negedge clk);
        n_checks++;
        if (a_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_redir: req_valid=%b, required 0", a_req_valid);
        end
        @(posedge clk);
        #1 a_redir = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_after: req_valid=%b, required 0", a_req_valid);
        end
        @(posedge clk);
        #1 a_hold = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_req_valid !== 1'b1 || a_req_pc !== 32'h200) begin
            n_fail++;
            $display("FAIL hold_release: valid=%b pc=%h, required 1 00000200", a_req_valid, a_req_pc);
        end
        repeat (10) @(posedge clk);
        test_drain_a();
    endtask

    task automatic test_flush_redir();
        @(posedge clk);
        #1 a_flush = 1'b1;
        a_flush_pc = 32'h300;
        a_redir = 1'b1;
        a_redir_pc = 32'h400;
        @(negedge clk);
        n_checks++;
        if (a_req_valid !== 1'b1 || a_req_pc !== 32'h300) begin
            n_fail++;
            $display("FAIL flush_wins: valid=%b pc=%h, required 1 00000300", a_req_valid, a_req_pc);
        end
        @(posedge clk);
        #1 a_flush = 1'b0;
        a_redir = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_req_valid !== 1'b1 || a_req_pc !== 32'h300) begin
            n_fail++;
            $display("FAIL flush_held: valid=%b pc=%h, required 1 00000300", a_req_valid, a_req_pc);
        end
        @(posedge clk);
        #1 a_req_ready = 1'b1;
        repeat (10) @(posedge clk);
        test_drain_a();
    endtask

    task automatic test_random_wrap();
        int n0, t = 0;
        @(posedge clk);
        #2 lat_b = 3;
        b_rand = 1'b1;
        n0 = b_ndel;
        repeat (150) @(posedge clk);
        #2 b_rand = 1'b0;
        b_req_ready = 1'b0;
        b_out_ready = 1'b1;
        @(negedge clk);
        while ((b_occ !== 3'd0 || mem_b.size() != 0) && t < 60) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (t >= 60 || exp_b.size() != 0 || b_ndel - n0 <= 16) begin
            n_fail++;
            $display("FAIL b_wrap: delivered=%0d undelivered=%0d occ=%0d, required >16 0 0", b_ndel - n0, exp_b.size(), b_occ);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk);
        #2 lat_b = 1;
        b_req_ready = 1'b1;
        b_out_ready = 1'b1;
        repeat (6) @(posedge clk);
        repeat (20) begin
            @(negedge clk);
            n_checks++;
            if (b_out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b_throughput: out_valid=%b, required 1", b_out_valid);
            end
        end
        @(posedge clk);
        #2 b_req_ready = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_hold_redir();
        test_flush_redir();
        test_random_wrap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
